// File: rtl/writeback_regfile.sv
// ============================================================================
// Module   : writeback_regfile
// Brief    : Writeback result select, load alignment/extension and 32x32
//            register file with optional same-cycle write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_regfile #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCPlus8W,
    input  logic [31:0] ALUOutW,
    input  logic [31:0] ReadDataW,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteW,
    input  logic        MemToRegW,
    input  logic        IsJJalW,
    input  logic        IsJrJalrW,
    input  logic        IsUnsignedW,
    input  logic [3:0]  BEOutW,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] ResultW,
    output logic [31:0] WriteCount
);

    localparam logic c_BYPASS_EN = (BYPASS != 0);

    logic [31:0] r_regs [0:31];
    logic [31:0] r_write_count;
    logic [31:0] w_load_data;
    logic [31:0] w_result;
    logic        w_write_req;
    logic        w_sign;

    // Sub-word loads extend from the selected lane's MSB unless unsigned.
    always_comb begin
        w_sign      = 1'b0;
        w_load_data = ReadDataW;
        case (BEOutW)
            4'b0001: begin
                w_sign      = ~IsUnsignedW & ReadDataW[7];
                w_load_data = {{24{w_sign}}, ReadDataW[7:0]};
            end
            4'b0010: begin
                w_sign      = ~IsUnsignedW & ReadDataW[15];
                w_load_data = {{24{w_sign}}, ReadDataW[15:8]};
            end
            4'b0100: begin
                w_sign      = ~IsUnsignedW & ReadDataW[23];
                w_load_data = {{24{w_sign}}, ReadDataW[23:16]};
            end
            4'b1000: begin
                w_sign      = ~IsUnsignedW & ReadDataW[31];
                w_load_data = {{24{w_sign}}, ReadDataW[31:24]};
            end
            4'b0011: begin
                w_sign      = ~IsUnsignedW & ReadDataW[15];
                w_load_data = {{16{w_sign}}, ReadDataW[15:0]};
            end
            4'b1100: begin
                w_sign      = ~IsUnsignedW & ReadDataW[31];
                w_load_data = {{16{w_sign}}, ReadDataW[31:16]};
            end
            default: begin
                w_sign      = 1'b0;
                w_load_data = ReadDataW;
            end
        endcase
    end

    always_comb begin
        w_result = ALUOutW;
        if (IsJJalW || IsJrJalrW) begin
            w_result = PCPlus8W;
        end else if (MemToRegW) begin
            w_result = w_load_data;
        end
    end

    assign w_write_req = RegWriteW && (WriteRegW != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_write_count <= 32'd0;
        end else if (w_write_req) begin
            r_regs[WriteRegW] <= w_result;
            r_write_count     <= r_write_count + 32'd1;
        end
    end

    // Forwarding ignores rst so a pending writeback stays visible while
    // the stored contents are being cleared.
    always_comb begin
        ReadData1 = 32'd0;
        if (ReadReg1 != 5'd0) begin
            if (c_BYPASS_EN && w_write_req && (WriteRegW == ReadReg1)) begin
                ReadData1 = w_result;
            end else begin
                ReadData1 = r_regs[ReadReg1];
            end
        end
    end

    always_comb begin
        ReadData2 = 32'd0;
        if (ReadReg2 != 5'd0) begin
            if (c_BYPASS_EN && w_write_req && (WriteRegW == ReadReg2)) begin
                ReadData2 = w_result;
            end else begin
                ReadData2 = r_regs[ReadReg2];
            end
        end
    end

    assign ResultW    = w_result;
    assign WriteCount = r_write_count;

endmodule

`default_nettype wire

// File: tb/tb_writeback_regfile.sv
// ============================================================================
// Module   : tb_writeback_regfile
// Brief    : Scoreboard bench driving a forwarding and a non-forwarding
//            instance of writeback_regfile from the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] PCPlus8W, ALUOutW, ReadDataW;
    logic [4:0]  WriteRegW, ReadReg1, ReadReg2;
    logic        RegWriteW, MemToRegW, IsJJalW, IsJrJalrW, IsUnsignedW;
    logic [3:0]  BEOutW;
    logic [31:0] rd1_b, rd2_b, res_b, cnt_b;
    logic [31:0] rd1_n, rd2_n, res_n, cnt_n;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] obs[$];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_count;
    int          n_cmp;
    int          n_err;

    writeback_regfile #(.BYPASS(1)) u_dut_byp (
        .clk(clk), .rst(rst), .PCPlus8W(PCPlus8W), .ALUOutW(ALUOutW),
        .ReadDataW(ReadDataW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .MemToRegW(MemToRegW), .IsJJalW(IsJJalW), .IsJrJalrW(IsJrJalrW),
        .IsUnsignedW(IsUnsignedW), .BEOutW(BEOutW), .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2), .ReadData1(rd1_b), .ReadData2(rd2_b),
        .ResultW(res_b), .WriteCount(cnt_b)
    );

    writeback_regfile #(.BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst(rst), .PCPlus8W(PCPlus8W), .ALUOutW(ALUOutW),
        .ReadDataW(ReadDataW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .MemToRegW(MemToRegW), .IsJJalW(IsJJalW), .IsJrJalrW(IsJrJalrW),
        .IsUnsignedW(IsUnsignedW), .BEOutW(BEOutW), .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2), .ReadData1(rd1_n), .ReadData2(rd2_n),
        .ResultW(res_n), .WriteCount(cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: lane picked by shifting, extension applied afterwards.
    function automatic logic [31:0] f_model_result();
        logic [31:0] v;
        int          sh;
        int          w;
        sh = 0;
        w  = 32;
        case (BEOutW)
            4'b0001: begin sh = 0;  w = 8;  end
            4'b0010: begin sh = 8;  w = 8;  end
            4'b0100: begin sh = 16; w = 8;  end
            4'b1000: begin sh = 24; w = 8;  end
            4'b0011: begin sh = 0;  w = 16; end
            4'b1100: begin sh = 16; w = 16; end
            default: begin sh = 0;  w = 32; end
        endcase
        v = ReadDataW >> sh;
        if (w == 8) begin
            v = (!IsUnsignedW && v[7]) ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
        end else if (w == 16) begin
            v = (!IsUnsignedW && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
        end
        if (IsJJalW || IsJrJalrW) return PCPlus8W;
        if (MemToRegW) return v;
        return ALUOutW;
    endfunction

    function automatic logic [31:0] f_model_read(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'd0;
        if (byp && RegWriteW && WriteRegW != 5'd0 && WriteRegW == idx)
            return f_model_result();
        return m_regs[idx];
    endfunction

    task automatic drive_idle();
        PCPlus8W = '0; ALUOutW = '0; ReadDataW = '0; WriteRegW = '0;
        RegWriteW = 0; MemToRegW = 0; IsJJalW = 0; IsJrJalrW = 0;
        IsUnsignedW = 0; BEOutW = '0; ReadReg1 = '0; ReadReg2 = '0;
    endtask

    // Advance one rising edge and mirror the commit in the model.
    task automatic tick();
        logic [31:0] r;
        r = f_model_result();
        @(posedge clk);
        if (!rst && RegWriteW && WriteRegW != 5'd0) begin
            m_regs[WriteRegW] = r;
            m_count           = m_count + 32'd1;
        end
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count = 32'd0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        RegWriteW = 1; WriteRegW = 5'd9; ALUOutW = 32'h0BAD_F00D; ReadReg1 = 5'd9;
        tick();
        RegWriteW = 0;
        sb.push_back('{"reset_cnt_byp", 32'd0});     obs.push_back(cnt_b);
        sb.push_back('{"reset_cnt_nobyp", 32'd0});   obs.push_back(cnt_n);
        sb.push_back('{"reset_noc_r9", 32'd0});      obs.push_back(rd1_n);
        @(negedge clk);
        rst = 1'b0;
        RegWriteW = 1; WriteRegW = 5'd9; ALUOutW = 32'h0000_1111;
        tick();
        RegWriteW = 0;
        sb.push_back('{"post_rst_r9", m_regs[9]});   obs.push_back(rd1_b);
        sb.push_back('{"post_rst_cnt", m_count});    obs.push_back(cnt_b);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive_idle();
        RegWriteW = 1; WriteRegW = 5'd5; ALUOutW = 32'h1234_5678;
        tick();
        @(negedge clk);
        drive_idle();
        ReadReg1 = 5'd5; ReadReg2 = 5'd5;
        #1;
        sb.push_back('{"wr5_rd1", 32'h1234_5678});      obs.push_back(rd1_b);
        sb.push_back('{"wr5_rd2_same", 32'h1234_5678}); obs.push_back(rd2_b);
        sb.push_back('{"wr5_rd1_nobyp", 32'h1234_5678}); obs.push_back(rd1_n);
        sb.push_back('{"wr5_count", m_count});          obs.push_back(cnt_b);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_load_extract();
        logic [3:0]  be_t  [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000,
                                    4'b0011, 4'b1100, 4'b1100, 4'b1111, 4'b0101};
        logic        uns_t [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
        logic [31:0] exp_t_[10] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF,
                                    32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01,
                                    32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01,
                                    32'h80FF_7F01};
        @(negedge clk);
        drive_idle();
        MemToRegW = 1; ReadDataW = 32'h80FF_7F01; ALUOutW = 32'h5555_5555;
        for (int i = 0; i < 10; i++) begin
            BEOutW = be_t[i]; IsUnsignedW = uns_t[i];
            #1;
            sb.push_back('{$sformatf("load_be%b_u%0d", be_t[i], uns_t[i]), exp_t_[i]});
            obs.push_back(res_b);
        end
        MemToRegW = 0;
        #1;
        sb.push_back('{"alu_select", 32'h5555_5555}); obs.push_back(res_n);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_link();
        @(negedge clk);
        drive_idle();
        IsJJalW = 1; PCPlus8W = 32'h0040_0010; WriteRegW = 5'd31; MemToRegW = 1;
        RegWriteW = 1; ReadDataW = 32'hFFFF_FFFF; BEOutW = 4'b1111;
        #1;
        sb.push_back('{"jal_result", 32'h0040_0010}); obs.push_back(res_b);
        tick();
        @(negedge clk);
        IsJJalW = 0; IsJrJalrW = 1; MemToRegW = 0; PCPlus8W = 32'h0040_0100;
        ALUOutW = 32'h1357_9BDF; WriteRegW = 5'd30;
        tick();
        @(negedge clk);
        drive_idle();
        ReadReg1 = 5'd31; ReadReg2 = 5'd30;
        #1;
        sb.push_back('{"jal_r31", 32'h0040_0010});  obs.push_back(rd1_n);
        sb.push_back('{"jalr_r30", 32'h0040_0100}); obs.push_back(rd2_n);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_r0();
        logic [31:0] cnt0;
        cnt0 = m_count;
        @(negedge clk);
        drive_idle();
        RegWriteW = 1; WriteRegW = 5'd0; ALUOutW = 32'hDEAD_BEEF; ReadReg1 = 5'd0;
        #1;
        sb.push_back('{"r0_bypass_rd1", 32'd0}); obs.push_back(rd1_b);
        tick();
        #1;
        sb.push_back('{"r0_after_rd1", 32'd0}); obs.push_back(rd1_b);
        sb.push_back('{"r0_count", cnt0});      obs.push_back(cnt_b);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive_idle();
        RegWriteW = 1; WriteRegW = 5'd7; ALUOutW = 32'h1111_2222;
        tick();
        @(negedge clk);
        ALUOutW = 32'hAAAA_5555; ReadReg2 = 5'd7; ReadReg1 = 5'd6;
        #1;
        sb.push_back('{"byp_rd2", 32'hAAAA_5555});   obs.push_back(rd2_b);
        sb.push_back('{"nobyp_rd2", 32'h1111_2222}); obs.push_back(rd2_n);
        sb.push_back('{"byp_other_rd1", m_regs[6]}); obs.push_back(rd1_b);
        tick();
        RegWriteW = 0;
        #1;
        sb.push_back('{"nobyp_rd2_after", 32'hAAAA_5555}); obs.push_back(rd2_n);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_between_edges();
        @(negedge clk);
        drive_idle();
        ReadReg1 = 5'd12;
        for (int i = 0; i < 4; i++) begin
            RegWriteW = 1; WriteRegW = 5'd12; ALUOutW = $urandom;
            #1;
        end
        RegWriteW = 0;
        tick();
        sb.push_back('{"glitch_r12", m_regs[12]}); obs.push_back(rd1_b);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            drive_idle();
            RegWriteW   = 1'($urandom_range(0, 3) != 0);
            WriteRegW   = 5'($urandom_range(0, 31));
            ALUOutW     = $urandom;
            ReadDataW   = $urandom;
            MemToRegW   = 1'($urandom_range(0, 1));
            BEOutW      = 4'($urandom_range(0, 15));
            IsUnsignedW = 1'($urandom_range(0, 1));
            ReadReg1    = ($urandom_range(0, 1) != 0) ? WriteRegW : 5'($urandom_range(0, 31));
            ReadReg2    = 5'($urandom_range(0, 31));
            sb.push_back('{"b2b_res", f_model_result()});            obs.push_back(32'd0);
            sb.push_back('{"b2b_rd1_byp", f_model_read(ReadReg1, 1)}); obs.push_back(32'd0);
            sb.push_back('{"b2b_rd2_byp", f_model_read(ReadReg2, 1)}); obs.push_back(32'd0);
            sb.push_back('{"b2b_rd1_nobyp", f_model_read(ReadReg1, 0)}); obs.push_back(32'd0);
            #1;
            obs[obs.size()-4] = res_b;
            obs[obs.size()-3] = rd1_b;
            obs[obs.size()-2] = rd2_b;
            obs[obs.size()-1] = rd1_n;
            tick();
            sb.push_back('{"b2b_count", m_count}); obs.push_back(cnt_b);
            while (sb.size() > 0) begin
                exp_t e;
                logic [31:0] o;
                e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
                if (o !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", e.name, o, e.val);
                end
            end
        end
    endtask

    task automatic test_midcycle_reset();
        @(negedge clk);
        drive_idle();
        ReadReg1 = 5'd5; ReadReg2 = 5'd31;
        #1;
        rst = 1'b1;
        #1;
        model_clear();
        sb.push_back('{"mrst_rd1_byp", 32'd0});   obs.push_back(rd1_b);
        sb.push_back('{"mrst_rd2_byp", 32'd0});   obs.push_back(rd2_b);
        sb.push_back('{"mrst_rd1_nobyp", 32'd0}); obs.push_back(rd1_n);
        sb.push_back('{"mrst_cnt_byp", 32'd0});   obs.push_back(cnt_b);
        sb.push_back('{"mrst_cnt_nobyp", 32'd0}); obs.push_back(cnt_n);
        rst = 1'b0;
        RegWriteW = 1; WriteRegW = 5'd5; ALUOutW = 32'hCAFE_0001;
        tick();
        RegWriteW = 0;
        #1;
        sb.push_back('{"mrst_first_write", 32'hCAFE_0001}); obs.push_back(rd1_n);
        sb.push_back('{"mrst_first_cnt", 32'd1});           obs.push_back(cnt_n);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive_idle();
        model_clear();
        test_reset();
        test_write_read();
        test_load_extract();
        test_link();
        test_r0();
        test_bypass();
        test_between_edges();
        test_back_to_back();
        test_midcycle_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
